pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage core, generalising the fixed-field per-stage latches (FD/DX/XM/MW) into one reusable block. It captures an instruction word, a control bundle and a datapath bundle each cycle. It also supports stall (hold), flush (bubble injection) and a valid bit, and keeps saturating stall and bubble performance counters. One instance sits between each pair of stages; hazard logic drives `stall`/`flush`.

---
 rtl/pipe_stage_reg.sv | 98 +++++++++
 tb/tb_pipe_stage_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable inter-stage pipeline register (FD/DX/XM/MW).
// It captures an instruction word, a control bundle and a datapath bundle on
// every rising edge. It supports stall (hold) and flush (bubble injection),
// and keeps saturating performance counters for stalls and bubbles.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid          upstream stage holds a real instruction
//   in_instr/ctrl/data upstream instruction, control bundle, datapath bundle
//   stall             hold current contents
//   flush             replace contents with a bubble (wins over stall)
//   cnt_clr           synchronous clear of both perf counters
//   out_valid/instr/ctrl/data  registered stage contents
//   stall_cnt         saturating count of stalled edges
//   bubble_cnt        saturating count of bubbles entered
module pipe_stage_reg #(
    parameter int unsigned       INSTR_W   = 16,
    parameter int unsigned       CTRL_W    = 24,
    parameter int unsigned       DATA_W    = 64,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               stall,
    input  logic               flush,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic load;
    logic stall_evt;
    logic bubble_evt;

    always_comb begin
        load       = 1'b0;
        stall_evt  = 1'b0;
        bubble_evt = 1'b0;
        load       = !flush && !stall;
        stall_evt  = stall && !flush;
        // A bubble enters either by an explicit flush or by loading an
        // invalid slot from upstream.
        bubble_evt = flush || (load && !in_valid);
    end

    // Pipeline contents. Control is forced to zero whenever the slot is
    // invalid, so a bubble cannot carry an architectural side effect.
    // out_data is not cleared on a bubble; it holds on flush and follows
    // in_data on bubble propagation.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_ctrl  <= '0;
        end else if (load) begin
            out_data <= in_data;
            if (in_valid) begin
                out_valid <= 1'b1;
                out_instr <= in_instr;
                out_ctrl  <= in_ctrl;
            end else begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
                out_ctrl  <= '0;
            end
        end
    end

    // Saturating perf counters. A clear wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble_evt && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CTRL_W  = 24;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP = 16'h0800;
    localparam logic [CNT_W-1:0]   CMAX = 4'hF;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic [CTRL_W-1:0]  in_ctrl;
    logic [DATA_W-1:0]  in_data;
    logic               stall;
    logic               flush;
    logic               cnt_clr;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [DATA_W-1:0]  out_data;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [CTRL_W-1:0]  ctrl;
        logic [DATA_W-1:0]  data;
        logic [CNT_W-1:0]   sc;
        logic [CNT_W-1:0]   bc;
    } exp_t;

    exp_t model;
    exp_t sb_q[$];

    pipe_stage_reg #(
        .INSTR_W   (INSTR_W),
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one edge's worth of inputs, predict the result, push it, then
    // pop and compare once the edge has happened.
    task automatic step(input logic r, input logic v, input logic [INSTR_W-1:0] i,
                        input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic s, input logic f, input logic clr);
        exp_t e;
        rst = r; in_valid = v; in_instr = i; in_ctrl = c; in_data = d;
        stall = s; flush = f; cnt_clr = clr;
        e = model;
        if (r) begin
            e.valid = 1'b0; e.instr = NOP; e.ctrl = '0; e.data = '0;
            e.sc = '0; e.bc = '0;
        end else begin
            if (f) begin
                e.valid = 1'b0; e.instr = NOP; e.ctrl = '0;
            end else if (!s) begin
                e.data = d;
                if (v) begin
                    e.valid = 1'b1; e.instr = i; e.ctrl = c;
                end else begin
                    e.valid = 1'b0; e.instr = NOP; e.ctrl = '0;
                end
            end
            if (clr) begin
                e.sc = '0; e.bc = '0;
            end else begin
                if (s && !f && model.sc != CMAX) e.sc = model.sc + 1'b1;
                if ((f || (!s && !v)) && model.bc != CMAX) e.bc = model.bc + 1'b1;
            end
        end
        model = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check("out_valid",  {63'd0, out_valid}, {63'd0, e.valid});
            check("out_instr",  {48'd0, out_instr}, {48'd0, e.instr});
            check("out_ctrl",   {40'd0, out_ctrl},  {40'd0, e.ctrl});
            check("out_data",   out_data,           e.data);
            check("stall_cnt",  {60'd0, stall_cnt}, {60'd0, e.sc});
            check("bubble_cnt", {60'd0, bubble_cnt}, {60'd0, e.bc});
        end
    endtask

    initial begin
        model = '0;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_ctrl = '0; in_data = '0;
        stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;

        // Reset then idle
        step(1, 0, 16'h0000, 24'h0, 64'h0, 0, 0, 0);
        check("rst_instr_const", {48'd0, out_instr}, 64'h0800);
        check("rst_data_const", out_data, 64'h0);

        // Load then stall three cycles with changing inputs
        step(0, 1, 16'hC123, 24'h0000A5, 64'hDEAD_BEEF, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            step(0, 1, 16'h4001 + 16'(k), 24'h000111, 64'h5555 + 64'(k), 1, 0, 0);
        check("stall_hold_instr", {48'd0, out_instr}, 64'hC123);
        check("stall_hold_ctrl", {40'd0, out_ctrl}, 64'h0000A5);
        check("stall_cnt_3", {60'd0, stall_cnt}, 64'd3);
        step(0, 1, 16'h4001, 24'h000222, 64'h7777, 0, 0, 0);
        check("load_after_stall", {48'd0, out_instr}, 64'h4001);

        // Flush beats stall
        step(0, 1, 16'hC123, 24'h0000A5, 64'hCAFE, 0, 0, 0);
        step(0, 1, 16'h9999, 24'h00ABCD, 64'hF00D, 1, 1, 0);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_data_held", out_data, 64'hCAFE);
        check("flush_bubble_cnt", {60'd0, bubble_cnt}, 64'd1);
        check("flush_stall_cnt", {60'd0, stall_cnt}, 64'd3);
        // Bubble held while stall stays high
        step(0, 1, 16'h1111, 24'h000001, 64'h1, 1, 0, 0);

        // Bubble propagation
        step(0, 0, 16'h2222, 24'hFFFFFF, 64'h1234, 0, 0, 0);
        check("bubble_ctrl_zero", {40'd0, out_ctrl}, 64'h0);
        check("bubble_data", out_data, 64'h1234);

        // Stall saturation then clear on a stalled edge
        for (int k = 0; k < 20; k++)
            step(0, 1, 16'h3333, 24'h000003, 64'h3, 1, 0, 0);
        check("stall_sat", {60'd0, stall_cnt}, 64'hF);
        step(0, 1, 16'h3333, 24'h000003, 64'h3, 1, 0, 1);
        check("clr_wins", {60'd0, stall_cnt}, 64'h0);

        // Bubble saturation
        for (int k = 0; k < 20; k++)
            step(0, 1, 16'h4444, 24'h000004, 64'h4, 0, 1, 0);
        check("bubble_sat", {60'd0, bubble_cnt}, 64'hF);

        // Mid-operation reset during a stall
        step(0, 1, 16'h5A5A, 24'h00005A, 64'h5A, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            step(0, 1, 16'h6666, 24'h000006, 64'h6, 1, 0, 0);
        check("stall_cnt_5", {60'd0, stall_cnt}, 64'd5);
        step(1, 1, 16'h7777, 24'h000007, 64'h7, 1, 0, 1);
        check("mid_rst_instr", {48'd0, out_instr}, 64'h0800);
        check("mid_rst_cnt", {60'd0, stall_cnt}, 64'd0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 INSTR_W'($urandom),
                 CTRL_W'($urandom),
                 {$urandom, $urandom},
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
